// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment scan controller.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF    = 7'b1111111;
    localparam seg_t SEG_HEX_0  = 7'b1000000;
    localparam seg_t SEG_HEX_1  = 7'b1111001;
    localparam seg_t SEG_HEX_2  = 7'b0100100;
    localparam seg_t SEG_HEX_3  = 7'b0110000;
    localparam seg_t SEG_HEX_4  = 7'b0011001;
    localparam seg_t SEG_HEX_5  = 7'b0010010;
    localparam seg_t SEG_HEX_6  = 7'b0000010;
    localparam seg_t SEG_HEX_7  = 7'b1111000;
    localparam seg_t SEG_HEX_8  = 7'b0000000;
    localparam seg_t SEG_HEX_9  = 7'b0010000;
    localparam seg_t SEG_HEX_A  = 7'b0001000;
    localparam seg_t SEG_HEX_B  = 7'b0000011;
    localparam seg_t SEG_HEX_C  = 7'b1000110;
    localparam seg_t SEG_HEX_D  = 7'b0100001;
    localparam seg_t SEG_HEX_E  = 7'b0000110;
    localparam seg_t SEG_HEX_F  = 7'b0001110;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned double buffering
// and leading-zero blanking. seg/dp switch on the same edge as digit_sel.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        enable,
    input  logic        blank_lz,
    output logic [1:0]  digit_sel,
    output seg_t        seg,
    output logic        dp,
    output logic        frame
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;
    logic             pending;
    logic [15:0]      disp_val;
    logic [3:0]       disp_dp;

    logic             tick;
    logic             wrap;
    logic [1:0]       digit_nxt;
    logic [15:0]      disp_val_nxt;
    logic [3:0]       disp_dp_nxt;
    logic [3:0]       nibble_nxt;
    logic             dp_req_nxt;
    logic             zero3;
    logic             zero2;
    logic             zero1;
    logic             blank_nxt;
    seg_t             hex_seg;

    // Next-slot view: the display register only swaps at the 3->0 wrap,
    // and seg/dp are derived from the digit and contents about to be shown.
    always_comb begin
        tick         = (cnt == CNT_MAX);
        wrap         = tick && (digit_sel == 2'd3);
        digit_nxt    = tick ? digit_sel + 2'd1 : digit_sel;
        disp_val_nxt = disp_val;
        disp_dp_nxt  = disp_dp;
        if (wrap && pending) begin
            disp_val_nxt = shadow_val;
            disp_dp_nxt  = shadow_dp;
        end

        nibble_nxt = disp_val_nxt[{digit_nxt, 2'b00} +: 4];
        dp_req_nxt = disp_dp_nxt[digit_nxt];

        // A digit is a leading zero when it and every digit above it is empty.
        zero3 = (disp_val_nxt[15:12] == 4'h0) && !disp_dp_nxt[3];
        zero2 = zero3 && (disp_val_nxt[11:8] == 4'h0) && !disp_dp_nxt[2];
        zero1 = zero2 && (disp_val_nxt[7:4]  == 4'h0) && !disp_dp_nxt[1];

        blank_nxt = 1'b0;
        case (digit_nxt)
            2'd3:    blank_nxt = blank_lz && zero3;
            2'd2:    blank_nxt = blank_lz && zero2;
            2'd1:    blank_nxt = blank_lz && zero1;
            default: blank_nxt = 1'b0;
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .hex (nibble_nxt),
        .seg (hex_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit_sel  <= 2'd0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            pending    <= 1'b0;
            disp_val   <= 16'h0000;
            disp_dp    <= 4'h0;
            frame      <= 1'b0;
        end else begin
            cnt       <= tick ? '0 : cnt + CNT_W'(1);
            digit_sel <= digit_nxt;
            frame     <= wrap;
            disp_val  <= disp_val_nxt;
            disp_dp   <= disp_dp_nxt;
            // A load coinciding with the wrap keeps pending set for the next frame.
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (wrap) begin
                pending    <= 1'b0;
            end
        end
    end

    // Outputs only move on tick edges so enable/blank_lz never glitch mid-slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (tick) begin
            seg <= (enable && !blank_nxt) ? hex_seg : SEG_OFF;
            dp  <= ~(enable && !blank_nxt && dp_req_nxt);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a cycle-count
// based reference model of the scan, buffering and blanking rules.
module tb_seg_scan_ctrl;

    localparam int TD = 4;
    localparam int FRAME_CYC = 4 * TD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        enable = 1'b1;
    logic        blank_lz = 1'b0;
    logic [1:0]  digit_sel;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .enable    (enable),
        .blank_lz  (blank_lz),
        .digit_sel (digit_sel),
        .seg       (seg),
        .dp        (dp),
        .frame     (frame)
    );

    always #5 clk = ~clk;

    // Reference model: slot position derived from the count of edges since reset.
    int          m_cyc;
    logic [15:0] m_sv, m_dv;
    logic [3:0]  m_sdp, m_ddp;
    bit          m_pend;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_frame;
    logic [1:0]  exp_digit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc     <= 0;
            m_sv      <= 16'h0;
            m_sdp     <= 4'h0;
            m_pend    <= 1'b0;
            m_dv      <= 16'h0;
            m_ddp     <= 4'h0;
            exp_seg   <= 7'h7F;
            exp_dp    <= 1'b1;
            exp_frame <= 1'b0;
            exp_digit <= 2'd0;
        end else begin
            automatic bit          tick = (m_cyc % TD) == TD - 1;
            automatic bit          wrap = tick && ((m_cyc / TD) % 4 == 3);
            automatic int          nd = ((m_cyc + 1) / TD) % 4;
            automatic logic [15:0] nv = m_dv;
            automatic logic [3:0]  ndp = m_ddp;
            automatic int          top = 0;
            automatic bit          blanked;
            if (wrap && m_pend) begin
                nv  = m_sv;
                ndp = m_sdp;
            end
            for (int i = 3; i >= 1; i--)
                if (top == 0 && (nv[4*i +: 4] != 4'h0 || ndp[i])) top = i;
            blanked = blank_lz && (nd > top);
            m_cyc <= m_cyc + 1;
            m_dv  <= nv;
            m_ddp <= ndp;
            if (load) begin
                m_sv   <= value;
                m_sdp  <= dp_in;
                m_pend <= 1'b1;
            end else if (wrap) begin
                m_pend <= 1'b0;
            end
            exp_digit <= 2'(nd);
            exp_frame <= wrap;
            if (tick) begin
                exp_seg <= (enable && !blanked) ? seg_tbl[nv[4*nd +: 4]] : 7'h7F;
                exp_dp  <= !(enable && !blanked && ndp[nd]);
            end
        end
    end

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_phase(input int ph, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            if (m_cyc % FRAME_CYC == ph) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (digit_sel !== 2'd0 || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values got digit=%0d seg=%b dp=%b frame=%b want 0 1111111 1 0",
                     digit_sel, seg, dp, frame);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= TD; k++) begin
            @(negedge clk);
            checks++;
            if (k < TD && (seg !== 7'h7F || digit_sel !== 2'd0)) begin
                errors++;
                $display("[TB] FAIL reset_quiet k=%0d got seg=%b digit=%0d want 1111111 0", k, seg, digit_sel);
            end else if (k == TD && (seg !== 7'b1000000 || digit_sel !== 2'd1)) begin
                errors++;
                $display("[TB] FAIL first_tick got seg=%b digit=%0d want 1000000 1", seg, digit_sel);
            end
        end
    endtask

    task automatic test_scan;
        int frames = 0;
        for (int c = 0; c < 20 * TD; c++) begin
            @(negedge clk);
            if (frame === 1'b1) frames++;
            checks++;
            if (digit_sel !== exp_digit || seg !== exp_seg || dp !== exp_dp || frame !== exp_frame) begin
                errors++;
                $display("[TB] FAIL scan c=%0d got %0d %b %b %b want %0d %b %b %b", c,
                         digit_sel, seg, dp, frame, exp_digit, exp_seg, exp_dp, exp_frame);
            end
        end
        checks++;
        if (frames != 5) begin
            errors++;
            $display("[TB] FAIL frame_count got %0d want 5", frames);
        end
    endtask

    task automatic test_load_midframe;
        bit ok;
        wait_phase(6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL midframe_wait got timeout want phase 6");
        end
        pulse_load(16'h12AF, 4'b0100);
        while (m_cyc % FRAME_CYC != 0) begin
            checks++;
            if (seg !== 7'b1000000 || dp !== 1'b1) begin
                errors++;
                $display("[TB] FAIL no_tear got seg=%b dp=%b want 1000000 1", seg, dp);
            end
            @(negedge clk);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2 * FRAME_CYC; c++) begin
                @(negedge clk);
                checks++;
                if (digit_sel !== exp_digit || seg !== exp_seg || dp !== exp_dp || frame !== exp_frame) begin
                    errors++;
                    $display("[TB] FAIL load r=%0d c=%0d got %0d %b %b %b want %0d %b %b %b", r, c,
                             digit_sel, seg, dp, frame, exp_digit, exp_seg, exp_dp, exp_frame);
                end
            end
            pulse_load(16'($urandom), 4'($urandom));
        end
    endtask

    task automatic test_blanking;
        logic [15:0] masks [4] = '{16'h00FF, 16'h0FFF, 16'h000F, 16'hFFFF};
        blank_lz = 1'b1;
        for (int r = 0; r < 6; r++) begin
            if (r == 0)      pulse_load(16'h0070, 4'h0);
            else if (r == 1) pulse_load(16'h0000, 4'h0);
            else             pulse_load(16'($urandom) & masks[r % 4], 4'($urandom) & 4'($urandom));
            for (int c = 0; c < 3 * FRAME_CYC; c++) begin
                @(negedge clk);
                checks++;
                if (digit_sel !== exp_digit || seg !== exp_seg || dp !== exp_dp) begin
                    errors++;
                    $display("[TB] FAIL blank r=%0d c=%0d got %0d %b %b want %0d %b %b", r, c,
                             digit_sel, seg, dp, exp_digit, exp_seg, exp_dp);
                end
                if (r == 0 && c >= 2 * FRAME_CYC) begin
                    checks++;
                    if ((digit_sel >= 2'd2 && seg !== 7'h7F) ||
                        (digit_sel == 2'd1 && seg !== 7'b1111000) ||
                        (digit_sel == 2'd0 && seg !== 7'b1000000)) begin
                        errors++;
                        $display("[TB] FAIL blank_0070 digit=%0d got seg=%b", digit_sel, seg);
                    end
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_load_on_wrap;
        bit ok;
        logic [15:0] a, b;
        a = 16'($urandom);
        b = {a[15:4], a[3:0] ^ 4'h5};
        wait_phase(5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wrap_wait_a got timeout want phase 5");
        end
        pulse_load(a, 4'h0);
        wait_phase(FRAME_CYC - 1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wrap_wait_b got timeout want phase 15");
        end
        pulse_load(b, 4'h0);
        checks++;
        if (digit_sel !== 2'd0 || seg !== seg_tbl[a[3:0]]) begin
            errors++;
            $display("[TB] FAIL frame_n_shows_a got digit=%0d seg=%b want 0 %b", digit_sel, seg, seg_tbl[a[3:0]]);
        end
        repeat (FRAME_CYC) @(negedge clk);
        checks++;
        if (digit_sel !== 2'd0 || seg !== seg_tbl[b[3:0]]) begin
            errors++;
            $display("[TB] FAIL frame_n1_shows_b got digit=%0d seg=%b want 0 %b", digit_sel, seg, seg_tbl[b[3:0]]);
        end
        for (int c = 0; c < 2 * FRAME_CYC; c++) begin
            @(negedge clk);
            checks++;
            if (digit_sel !== exp_digit || seg !== exp_seg || dp !== exp_dp || frame !== exp_frame) begin
                errors++;
                $display("[TB] FAIL wrap c=%0d got %0d %b %b %b want %0d %b %b %b", c,
                         digit_sel, seg, dp, frame, exp_digit, exp_seg, exp_dp, exp_frame);
            end
        end
    endtask

    task automatic test_enable;
        int moves = 0;
        logic [1:0] last;
        pulse_load(16'h8A3C, 4'b1011);
        enable = 1'b0;
        last = digit_sel;
        for (int c = 0; c < 2 * FRAME_CYC; c++) begin
            @(negedge clk);
            if (digit_sel !== last) moves++;
            last = digit_sel;
            checks++;
            if (digit_sel !== exp_digit || seg !== exp_seg || dp !== exp_dp) begin
                errors++;
                $display("[TB] FAIL disabled_model c=%0d got %0d %b %b want %0d %b %b", c,
                         digit_sel, seg, dp, exp_digit, exp_seg, exp_dp);
            end
            if (c >= TD) begin
                checks++;
                if (seg !== 7'h7F || dp !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL disabled_off c=%0d got seg=%b dp=%b want 1111111 1", c, seg, dp);
                end
            end
        end
        checks++;
        if (moves != 2 * FRAME_CYC / TD) begin
            errors++;
            $display("[TB] FAIL disabled_scan got %0d moves want %0d", moves, 2 * FRAME_CYC / TD);
        end
        enable = 1'b1;
        for (int c = 0; c < FRAME_CYC + TD; c++) begin
            @(negedge clk);
            checks++;
            if (digit_sel !== exp_digit || seg !== exp_seg || dp !== exp_dp) begin
                errors++;
                $display("[TB] FAIL reenable c=%0d got %0d %b %b want %0d %b %b", c,
                         digit_sel, seg, dp, exp_digit, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_async_reset;
        int guard = 0;
        pulse_load(16'h5678, 4'b1111);
        while ((exp_digit !== 2'd2 || seg === 7'h7F) && guard < 8 * FRAME_CYC) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 8 * FRAME_CYC) begin
            errors++;
            $display("[TB] FAIL async_wait got timeout want lit digit 2");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (digit_sel !== 2'd0 || seg !== 7'h7F || dp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got digit=%0d seg=%b dp=%b frame=%b want 0 1111111 1 0",
                     digit_sel, seg, dp, frame);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= TD; k++) begin
            @(negedge clk);
            checks++;
            if (k < TD && (seg !== 7'h7F || digit_sel !== 2'd0)) begin
                errors++;
                $display("[TB] FAIL post_reset_quiet k=%0d got seg=%b digit=%0d want 1111111 0", k, seg, digit_sel);
            end else if (k == TD && (seg !== 7'b1000000 || digit_sel !== 2'd1)) begin
                errors++;
                $display("[TB] FAIL post_reset_tick got seg=%b digit=%0d want 1000000 1", seg, digit_sel);
            end
        end
        for (int c = 0; c < 2 * FRAME_CYC; c++) begin
            @(negedge clk);
            checks++;
            if (digit_sel !== exp_digit || seg !== exp_seg || dp !== exp_dp || frame !== exp_frame) begin
                errors++;
                $display("[TB] FAIL post_reset c=%0d got %0d %b %b %b want %0d %b %b %b", c,
                         digit_sel, seg, dp, frame, exp_digit, exp_seg, exp_dp, exp_frame);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan();
        test_load_midframe();
        test_blanking();
        test_load_on_wrap();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
